wb_sram_ctrl: RTL and testbench



---
 rtl/wb_sram_ctrl.sv | 132 +++++++++++++
 tb/tb_wb_sram_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave in front of the banked 1024x32 SRAM wrapper.
// Optionally zero-fills the whole array after reset before accepting traffic.
//
// state | meaning
// ------+------------------------------------------------------------
// CLEAR | zero-fill sweep, one word per cycle, WB requests held off
// IDLE  | sample WB request, drive SRAM strobes combinationally
// RD    | SRAM read in flight, capture sram_do at the edge
// ACK   | single-cycle ack, request not re-sampled here
module wb_sram_ctrl #(
  parameter int RAM_BLOCKS     = 2,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(RAM_BLOCKS) + 10,
  localparam int unsigned DEPTH = RAM_BLOCKS * 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          init_done,
  output logic          sram_en,
  output logic          sram_r_wb,
  output logic [31:0]   sram_ben,
  output logic [AW-1:0] sram_ad,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          rd_oor;
  logic [AW-1:0] word_adr;
  logic          in_range;
  logic          req;
  logic          unused_adr;

  assign word_adr   = wbs_adr_i[AW+1:2];
  // Only reachable as false when RAM_BLOCKS is not a power of two.
  assign in_range   = (32'(word_adr) < DEPTH);
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

  // SRAM strobes: clear sweep, or pass-through of the WB request while IDLE.
  always_comb begin
    sram_en   = 1'b0;
    sram_r_wb = 1'b1;
    sram_ben  = '0;
    sram_ad   = '0;
    sram_di   = '0;
    if (!wb_rst_i) begin
      case (state)
        S_CLEAR: begin
          sram_en   = 1'b1;
          sram_r_wb = 1'b0;
          sram_ben  = '1;
          sram_ad   = clr_cnt;
          sram_di   = '0;
        end
        S_IDLE: begin
          sram_en   = req & in_range;
          sram_r_wb = ~wbs_we_i;
          sram_ad   = word_adr;
          sram_di   = wbs_dat_i;
          sram_ben  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}} & {32{wbs_we_i}};
        end
        default: ;
      endcase
    end
  end

  // Sequencer: clear sweep, request acceptance, read capture and ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      rd_oor    <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == CLR_LAST) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          init_done <= 1'b1;
          if (req) begin
            rd_oor <= ~in_range;
            if (wbs_we_i) begin
              state     <= S_ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          // Data is captured even when the master has abandoned the cycle.
          wbs_dat_o <= rd_oor ? 32'h0 : sram_do;
          if (wbs_cyc_i) begin
            state     <= S_ACK;
            wbs_ack_o <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench: two controller instances (2 banks with clear, 3 banks without)
// each backed by a behavioural SRAM array.
module tb_wb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: RAM_BLOCKS=2, CLEAR_ON_RESET=1
  logic        rst0 = 1'b1;
  logic        cyc0 = 0, stb0 = 0, we0 = 0;
  logic [3:0]  sel0 = 0;
  logic [31:0] adr0 = 0, dati0 = 0;
  logic        ack0, init0, en0, rwb0;
  logic [31:0] dato0, ben0, di0;
  logic [31:0] do0 = 32'h0;
  logic [10:0] ad0;
  logic [31:0] mem0 [0:2047];

  // Instance 1: RAM_BLOCKS=3, CLEAR_ON_RESET=0
  logic        rst1 = 1'b1;
  logic        cyc1 = 0, stb1 = 0, we1 = 0;
  logic [3:0]  sel1 = 0;
  logic [31:0] adr1 = 0, dati1 = 0;
  logic        ack1, init1, en1, rwb1;
  logic [31:0] dato1, ben1, di1;
  logic [31:0] do1 = 32'hFFFF_FFFF;
  logic [11:0] ad1;
  logic [31:0] mem1 [0:4095];
  logic        en1_oor_seen = 1'b0;

  wb_sram_ctrl #(.RAM_BLOCKS(2), .CLEAR_ON_RESET(1'b1)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst0), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0),
    .wbs_we_i(we0), .wbs_sel_i(sel0), .wbs_adr_i(adr0), .wbs_dat_i(dati0),
    .wbs_ack_o(ack0), .wbs_dat_o(dato0), .init_done(init0), .sram_en(en0),
    .sram_r_wb(rwb0), .sram_ben(ben0), .sram_ad(ad0), .sram_di(di0), .sram_do(do0));

  wb_sram_ctrl #(.RAM_BLOCKS(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst1), .wbs_cyc_i(cyc1), .wbs_stb_i(stb1),
    .wbs_we_i(we1), .wbs_sel_i(sel1), .wbs_adr_i(adr1), .wbs_dat_i(dati1),
    .wbs_ack_o(ack1), .wbs_dat_o(dato1), .init_done(init1), .sram_en(en1),
    .sram_r_wb(rwb1), .sram_ben(ben1), .sram_ad(ad1), .sram_di(di1), .sram_do(do1));

  initial begin
    for (int i = 0; i < 2048; i++) mem0[i] = 32'hC0DE_0000 | i;
    for (int i = 0; i < 4096; i++) mem1[i] = 32'h5A5A_5A5A;
  end

  // Behavioural SRAMs: read data valid after the enabled read edge, bit-masked writes.
  always @(posedge clk) begin
    if (en0) begin
      if (rwb0) do0 <= mem0[ad0];
      else      mem0[ad0] <= (mem0[ad0] & ~ben0) | (di0 & ben0);
    end
    if (en1) begin
      if (rwb1) do1 <= mem1[ad1];
      else      mem1[ad1] <= (mem1[ad1] & ~ben1) | (di1 & ben1);
    end
    if (en1 && ad1 >= 12'd3072) en1_oor_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One WB transfer started at a negedge; returns data, ack latency and the
  // SRAM strobes seen in the request cycle. Ends at a negedge with FSM idle.
  task automatic wb_xfer(input bit dut, input bit we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdata, output int lat,
                         output logic en_s, output logic rwb_s,
                         output logic [31:0] ben_s, output logic [31:0] ad_s);
    bit got;
    if (dut) begin cyc1 = 1; stb1 = 1; we1 = we; sel1 = sel; adr1 = adr; dati1 = dat; end
    else     begin cyc0 = 1; stb0 = 1; we0 = we; sel0 = sel; adr0 = adr; dati0 = dat; end
    #1;
    en_s  = dut ? en1  : en0;
    rwb_s = dut ? rwb1 : rwb0;
    ben_s = dut ? ben1 : ben0;
    ad_s  = dut ? 32'(ad1) : 32'(ad0);
    lat = 0;
    got = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = dut ? ack1 : ack0;
    end
    rdata = dut ? dato1 : dato0;
    if (dut) begin cyc1 = 0; stb1 = 0; end
    else     begin cyc0 = 0; stb0 = 0; end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, ben_s, ad_s;
    logic        en_s, rwb_s;
    int          lat, n, nz;
    bit          bad_clear, early_ack;

    // ---------------- reset values ----------------
    repeat (2) @(negedge clk);
    check("rst_ack",  32'(ack0),  0);
    check("rst_dato", dato0,      0);
    check("rst_init", 32'(init0), 0);
    check("rst_en",   32'(en0),   0);
    check("rst_rwb",  32'(rwb0),  1);
    check("rst_ben",  ben0,       0);
    check("rst_ad",   32'(ad0),   0);
    check("rst_di",   di0,        0);

    // ---------------- post-reset clear ----------------
    rst0 = 0;
    #1;
    check("clr_first_ad", 32'(ad0), 0);
    @(negedge clk);
    n = 0;
    bad_clear = 0;
    while (n < 5000) begin
      n++;
      if (init0) break;
      if (!(en0 && !rwb0 && ben0 == 32'hFFFF_FFFF && di0 == 0 && 32'(ad0) == n))
        bad_clear = 1;
      @(negedge clk);
    end
    check("clr_cycles", n, 2048);
    check("clr_strobes", 32'(bad_clear), 0);
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem0[i] != 0) nz++;
    check("clr_array_zero", nz, 0);
    wb_xfer(0, 0, 4'h0, 32'h0000_1FFC, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("clr_rd_last", rd, 0);

    // ---------------- write / read back ----------------
    wb_xfer(0, 1, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("wr_lat", lat, 1);
    check("wr_ad", ad_s, 32'h401);
    check("wr_en", 32'(en_s), 1);
    check("wr_rwb", 32'(rwb_s), 0);
    check("wr_ben", ben_s, 32'hFFFF_FFFF);
    wb_xfer(0, 0, 4'hF, 32'h0000_1004, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_ad", ad_s, 32'h401);
    check("rd_rwb", 32'(rwb_s), 1);
    check("rd_ben", ben_s, 0);

    // ---------------- partial and empty byte selects ----------------
    wb_xfer(0, 1, 4'hF, 32'h0000_0100, 32'h1122_3344, rd, lat, en_s, rwb_s, ben_s, ad_s);
    wb_xfer(0, 1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("part_ben", ben_s, 32'h00FF_00FF);
    wb_xfer(0, 0, 4'hF, 32'h0000_0100, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("part_rd", rd, 32'h11BB_33DD);
    wb_xfer(0, 1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("sel0_en", 32'(en_s), 1);
    check("sel0_ben", ben_s, 0);
    check("sel0_lat", lat, 1);
    wb_xfer(0, 0, 4'hF, 32'h0000_0100, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("sel0_rd", rd, 32'h11BB_33DD);

    // ---------------- read aborted in RD ----------------
    cyc0 = 1; stb0 = 1; we0 = 0; sel0 = 4'hF; adr0 = 32'h0000_1004;
    @(negedge clk);
    cyc0 = 0; stb0 = 0;
    check("abort_ack_rd", 32'(ack0), 0);
    @(negedge clk);
    check("abort_ack_next", 32'(ack0), 0);
    check("abort_dato", dato0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("abort_ack_late", 32'(ack0), 0);
    wb_xfer(0, 1, 4'hF, 32'h0000_1008, 32'h1234_5678, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("abort_wr_lat", lat, 1);
    wb_xfer(0, 0, 4'hF, 32'h0000_1008, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("abort_wr_rd", rd, 32'h1234_5678);

    // ---------------- 3-bank instance, no clear ----------------
    check("nc_init_rst", 32'(init1), 0);
    rst1 = 0;
    @(negedge clk);
    check("nc_init", 32'(init1), 1);
    wb_xfer(1, 1, 4'hF, 32'h0000_2FFC, 32'hCAFE_F00D, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("top_wr_en", 32'(en_s), 1);
    check("top_wr_ad", ad_s, 32'hBFF);
    wb_xfer(1, 0, 4'hF, 32'h0000_2FFC, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("top_rd", rd, 32'hCAFE_F00D);
    wb_xfer(1, 1, 4'hF, 32'h0000_3000, 32'h0BAD_0BAD, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("oor_wr_en", 32'(en_s), 0);
    check("oor_wr_lat", lat, 1);
    wb_xfer(1, 0, 4'hF, 32'h0000_3000, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("oor_rd_en", 32'(en_s), 0);
    check("oor_rd_lat", lat, 2);
    check("oor_rd_data", rd, 0);
    check("oor_en_never", 32'(en1_oor_seen), 0);

    // ---------------- reset in the middle of a clear ----------------
    rst0 = 1;
    @(negedge clk);
    rst0 = 0;
    repeat (500) @(negedge clk);
    check("mid_ad500", 32'(ad0), 500);
    rst0 = 1;
    @(negedge clk);
    check("mid_init_rst", 32'(init0), 0);
    rst0 = 0;
    #1;
    check("mid_ad_restart", 32'(ad0), 0);
    check("mid_en", 32'(en0), 1);
    cyc0 = 1; stb0 = 1; we0 = 1; sel0 = 4'hF; adr0 = 32'h0000_0014; dati0 = 32'h0BAD_F00D;
    @(negedge clk);
    n = 0;
    early_ack = 0;
    while (n < 5000) begin
      n++;
      if (init0) break;
      if (ack0) early_ack = 1;
      @(negedge clk);
    end
    check("mid_clr_cycles", n, 2048);
    check("mid_no_early_ack", 32'(early_ack), 0);
    lat = 0;
    while (!ack0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("mid_held_ack_lat", lat, 1);
    cyc0 = 0; stb0 = 0;
    @(negedge clk);
    wb_xfer(0, 0, 4'hF, 32'h0000_0014, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("mid_held_rd", rd, 32'h0BAD_F00D);
    wb_xfer(0, 0, 4'hF, 32'h0000_1004, 0, rd, lat, en_s, rwb_s, ben_s, ad_s);
    check("mid_recleared", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
